crosswalk_controller: RTL
=========================

CROSSWALK_CONTROLLER -- requirements
Module: crosswalk_controller

Interface
REQ-001 Parameter DEBOUNCE_N, default 16, is the number of consecutive clk cycles of stable synchronized button level required before the debounced level changes.
REQ-002 Parameter TICK_DIV, default 2097152, is the number of clk cycles per timing tick.
REQ-003 Parameter WALK_TON, default 10, is the maximum WALK duration in ticks.
REQ-004 Parameter FLASH_MAX, default 12, is the maximum FLASH duration in ticks.
REQ-005 clk  input  1  single clock, all logic rising-edge triggered.
REQ-006 reset_n  input  1  reset, asynchronous, active-high (1 = reset) despite the name.
REQ-007 button  input  1  raw asynchronous pedestrian push-button, 1 = pressed.
REQ-008 par_red, par_ylw, par_grn  input  1 each  one-hot red/yellow/green lamp of the vehicle light parallel to this crosswalk.
REQ-009 xwalk_rqst  output  1  crossing request to the intersection controller (drives its crosswalk_N input).
REQ-010 walk  output  1  WALK lamp.
REQ-011 dont_walk  output  1  DON'T WALK lamp, solid or flashing.
REQ-012 rqst_lamp  output  1  "request accepted" indicator.

Function
REQ-013 button shall pass a 2-flop synchronizer, then a debounce counter; debounced level updates only after DEBOUNCE_N consecutive equal synchronized samples; press event = debounced 0->1 edge, 1-cycle pulse.
REQ-014 Tick = 1-cycle pulse every TICK_DIV clk cycles from a free-running prescaler; all tick counts in REQ-017..019 count tick pulses only.
REQ-015 Light inputs valid only when exactly one of par_red/par_ylw/par_grn is 1; any other combination is a fault.
REQ-016 States: IDLE, WAIT, WALK, FLASH, DONE; all outputs registered, derived from state.
REQ-017 IDLE: dont_walk=1 solid, walk=0, xwalk_rqst=0, rqst_lamp=0; press -> WAIT.
REQ-018 WAIT: xwalk_rqst=1, rqst_lamp=1, dont_walk=1 solid; par_grn=1 (valid) -> WALK, tick counter cleared; further presses ignored.
REQ-019 WALK: walk=1, dont_walk=0, xwalk_rqst=1, rqst_lamp=0; exits to FLASH when par_grn=0 or WALK_TON ticks elapsed, whichever first.
REQ-020 FLASH: walk=0, xwalk_rqst=0, dont_walk toggles on every tick starting at 1 on entry; exits to DONE when par_red=1 or FLASH_MAX ticks elapsed.
REQ-021 DONE: dont_walk=1 solid, one clk cycle; -> WAIT if next_rqst set (then clear it), else IDLE.
REQ-022 A press during WALK or FLASH shall set next_rqst and rqst_lamp=1; multiple presses equal one.
REQ-023 Fault (REQ-015) in any state shall within 1 cycle force walk=0, dont_walk=1 solid, xwalk_rqst=0 and go to IDLE, clearing next_rqst; remains IDLE-blocked (presses ignored) until light inputs are valid.
REQ-024 walk shall never be 1 in any cycle where the registered light sample has par_grn=0 for more than 1 cycle.
REQ-025 Press and state exit in the same cycle: exit taken; press handled per the destination state's rule (in DONE it sets next_rqst).
REQ-026 Counters shall saturate, not wrap; prescaler wraps at TICK_DIV-1 to 0.

Reset
REQ-027 reset_n=1 shall immediately force IDLE, walk=0, dont_walk=1, xwalk_rqst=0, rqst_lamp=0, next_rqst=0, clear synchronizer, debounce, prescaler and tick counters.
REQ-028 Reset mid-WALK shall drop walk in the same cycle (asynchronously); a button held across reset release shall not produce a press until released and re-pressed.

Verification (DEBOUNCE_N=4, TICK_DIV=2, WALK_TON=5, FLASH_MAX=6)
REQ-029 Glitch: button high 3 cycles then low -> no press, stays IDLE, xwalk_rqst=0.
REQ-030 Full cycle: press held 10 cycles with par_red=1 -> xwalk_rqst=1 within 7 cycles; par_grn=1 -> walk=1 next cycle; hold green -> FLASH after 5 ticks (10 cycles); par_red=1 -> DONE -> IDLE, dont_walk solid.
REQ-031 Early green drop: in WALK at tick 2 set par_ylw=1 -> walk=0 within 1 cycle, dont_walk toggling every 2 cycles.
REQ-032 Queued request: press during FLASH -> rqst_lamp=1; after DONE, WAIT with xwalk_rqst=1.
REQ-033 Fault: in WALK drive par_grn=par_red=1 -> next cycle walk=0, dont_walk=1, xwalk_rqst=0, IDLE; press ignored until valid.
REQ-034 Reset: assert reset_n mid-WALK -> walk=0, dont_walk=1 without clk edge; held button after release produces no request.

Source files
------------

// File: rtl/crosswalk_controller.sv
// Pedestrian crosswalk controller: debounced push-button, tick prescaler and a
// WALK / flashing DON'T WALK sequencer slaved to the parallel vehicle light.
module crosswalk_controller #(
    parameter int DEBOUNCE_N = 16,
    parameter int TICK_DIV   = 2097152,
    parameter int WALK_TON   = 10,
    parameter int FLASH_MAX  = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    input  logic par_red,
    input  logic par_ylw,
    input  logic par_grn,
    output logic xwalk_rqst,
    output logic walk,
    output logic dont_walk,
    output logic rqst_lamp
);

    localparam int DB_W = $clog2(DEBOUNCE_N + 1);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (WALK_TON > FLASH_MAX) ? WALK_TON : FLASH_MAX;
    localparam int TC_W = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, WAIT, WALK, FLASH, DONE} state_t;

    state_t            state, state_nxt;
    logic              sync1, sync2;
    logic [1:0]        sync_fill;
    logic [DB_W-1:0]   db_cnt;
    logic              db_level, db_prev, armed;
    logic [PS_W-1:0]   presc;
    logic [TC_W-1:0]   tick_cnt, tick_cnt_nxt;
    logic              next_rqst, next_rqst_nxt;
    logic              walk_nxt, dont_walk_nxt, xwalk_rqst_nxt, rqst_lamp_nxt;
    logic              tick, press, fault;

    assign tick  = (presc == PS_W'(TICK_DIV - 1));
    assign press = db_level & ~db_prev & armed;
    assign fault = !$onehot({par_red, par_ylw, par_grn});

    // armed stays low until a released button is seen after reset, so a button
    // held through reset release never turns into a press
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_fill <= 2'b00;
            db_cnt    <= '0;
            db_level  <= 1'b0;
            db_prev   <= 1'b0;
            armed     <= 1'b0;
            presc     <= '0;
        end else begin
            sync1     <= button;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_N - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            db_prev <= db_level;
            if (sync_fill[1] && !sync2 && !db_level) begin
                armed <= 1'b1;
            end
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            next_rqst  <= 1'b0;
            walk       <= 1'b0;
            dont_walk  <= 1'b1;
            xwalk_rqst <= 1'b0;
            rqst_lamp  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            next_rqst  <= next_rqst_nxt;
            walk       <= walk_nxt;
            dont_walk  <= dont_walk_nxt;
            xwalk_rqst <= xwalk_rqst_nxt;
            rqst_lamp  <= rqst_lamp_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        next_rqst_nxt = next_rqst;
        if (fault) begin
            state_nxt     = IDLE;
            next_rqst_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) state_nxt = WAIT;
                end
                WAIT: begin
                    if (par_grn) begin
                        state_nxt    = WALK;
                        tick_cnt_nxt = '0;
                    end
                end
                WALK: begin
                    if (!par_grn || (tick && tick_cnt >= TC_W'(WALK_TON - 1))) begin
                        state_nxt    = FLASH;
                        tick_cnt_nxt = '0;
                    end else if (tick && tick_cnt < TC_W'(TMAX)) begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                FLASH: begin
                    if (par_red || (tick && tick_cnt >= TC_W'(FLASH_MAX - 1))) begin
                        state_nxt = DONE;
                    end else if (tick && tick_cnt < TC_W'(TMAX)) begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (next_rqst || press) begin
                        state_nxt     = WAIT;
                        next_rqst_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // a press coinciding with an exit follows the destination's rule
            if (press && (state_nxt == WALK || state_nxt == FLASH || state_nxt == DONE)) begin
                next_rqst_nxt = 1'b1;
            end
        end

        walk_nxt       = (state_nxt == WALK);
        xwalk_rqst_nxt = (state_nxt == WAIT) || (state_nxt == WALK);
        rqst_lamp_nxt  = (state_nxt == WAIT) || next_rqst_nxt;
        if (state_nxt == WALK) begin
            dont_walk_nxt = 1'b0;
        end else if (state_nxt == FLASH && state == FLASH) begin
            dont_walk_nxt = tick ? ~dont_walk : dont_walk;
        end else begin
            dont_walk_nxt = 1'b1;
        end
    end

endmodule
